// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Holds the arbiter FSM state encoding used by the top and its bench.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between IF fetches and MEM loads/stores.
// Data accesses win over fetches; stall/bubble controls are exported to the pipeline top.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 InstrReqF,
    input  logic [WIDTH-1:0]     PCF,
    input  logic                 HazStallF,
    input  logic                 FetchKill,
    input  logic                 DataReqM,
    input  logic                 MemWriteM,
    input  logic [WIDTH-1:0]     ALUOutM,
    input  logic [WIDTH-1:0]     WriteDataM,
    output logic                 MemReq,
    output logic                 MemWE,
    output logic [WIDTH-1:0]     MemAddr,
    output logic [WIDTH-1:0]     MemWData,
    input  logic                 MemAck,
    input  logic [WIDTH-1:0]     MemRData,
    output logic [WIDTH-1:0]     InstrF,
    output logic                 InstrValidF,
    output logic [WIDTH-1:0]     ReadDataM,
    output logic                 DataDoneM,
    output logic                 StallAllMem,
    output logic                 FlushWMem,
    output logic                 StallFMem,
    output logic                 FlushDMem,
    output logic [CNT_WIDTH-1:0] StallCycles
);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic                  r_squash;
    logic                  w_squash_nxt;
    logic                  w_grant_data;
    logic                  w_grant_fetch;
    logic                  w_data_ack;
    logic                  w_fetch_accept;
    logic                  w_consume;
    logic                  w_req_nxt;
    logic                  w_we_nxt;
    logic [WIDTH-1:0]      w_addr_nxt;
    logic [WIDTH-1:0]      w_wdata_nxt;
    logic [WIDTH-1:0]      w_instr_nxt;
    logic                  w_valid_nxt;
    logic [WIDTH-1:0]      w_rdata_nxt;
    logic                  w_done_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;

    assign StallAllMem = DataReqM & ~DataDoneM;
    assign FlushWMem   = StallAllMem;
    assign StallFMem   = InstrReqF & ~InstrValidF & ~StallAllMem;
    assign FlushDMem   = StallFMem;

    // DataDoneM blocks a re-grant while the completed MEM op is still presented.
    assign w_grant_data   = (r_state == ST_IDLE) & DataReqM & ~DataDoneM;
    assign w_grant_fetch  = (r_state == ST_IDLE) & ~w_grant_data & InstrReqF & ~InstrValidF & ~FetchKill;
    assign w_data_ack     = (r_state == ST_DATA) & MemAck;
    assign w_fetch_accept = (r_state == ST_FETCH) & MemAck & ~r_squash & ~FetchKill;
    assign w_consume      = InstrValidF & ~StallAllMem & ~HazStallF;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_data) begin
                    w_state_nxt = ST_DATA;
                end else if (w_grant_fetch) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA, ST_FETCH: begin
                if (MemAck) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory request side: the granted request is latched once and held until ack.
    always_comb begin
        w_req_nxt    = MemReq;
        w_we_nxt     = MemWE;
        w_addr_nxt   = MemAddr;
        w_wdata_nxt  = MemWData;
        w_squash_nxt = r_squash;
        case (r_state)
            ST_IDLE: begin
                w_squash_nxt = 1'b0;
                if (w_grant_data) begin
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = MemWriteM;
                    w_addr_nxt  = ALUOutM;
                    w_wdata_nxt = WriteDataM;
                end else if (w_grant_fetch) begin
                    w_req_nxt  = 1'b1;
                    w_we_nxt   = 1'b0;
                    w_addr_nxt = PCF;
                end else begin
                    w_req_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                w_req_nxt = ~MemAck;
            end
            ST_FETCH: begin
                w_req_nxt = ~MemAck;
                if (MemAck) begin
                    w_squash_nxt = 1'b0;
                end else if (FetchKill) begin
                    w_squash_nxt = 1'b1;
                end else begin
                    w_squash_nxt = r_squash;
                end
            end
            default: begin
                w_req_nxt    = 1'b0;
                w_squash_nxt = 1'b0;
            end
        endcase
    end

    // Response side and stall counter; FetchKill outranks both fill and consumption.
    always_comb begin
        w_done_nxt = w_data_ack;
        if (w_data_ack && !MemWE) begin
            w_rdata_nxt = MemRData;
        end else begin
            w_rdata_nxt = ReadDataM;
        end
        if (w_fetch_accept) begin
            w_instr_nxt = MemRData;
        end else begin
            w_instr_nxt = InstrF;
        end
        if (FetchKill) begin
            w_valid_nxt = 1'b0;
        end else if (w_fetch_accept) begin
            w_valid_nxt = 1'b1;
        end else if (w_consume) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = InstrValidF;
        end
        if ((StallAllMem || StallFMem) && !(&StallCycles)) begin
            w_cnt_nxt = StallCycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = StallCycles;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_squash    <= 1'b0;
            MemReq      <= 1'b0;
            MemWE       <= 1'b0;
            MemAddr     <= {WIDTH{1'b0}};
            MemWData    <= {WIDTH{1'b0}};
            InstrF      <= {WIDTH{1'b0}};
            InstrValidF <= 1'b0;
            ReadDataM   <= {WIDTH{1'b0}};
            DataDoneM   <= 1'b0;
            StallCycles <= {CNT_WIDTH{1'b0}};
        end else begin
            r_squash    <= w_squash_nxt;
            MemReq      <= w_req_nxt;
            MemWE       <= w_we_nxt;
            MemAddr     <= w_addr_nxt;
            MemWData    <= w_wdata_nxt;
            InstrF      <= w_instr_nxt;
            InstrValidF <= w_valid_nxt;
            ReadDataM   <= w_rdata_nxt;
            DataDoneM   <= w_done_nxt;
            StallCycles <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter: one row per clock cycle of a
// fetch/load/store/kill/hold scenario, then reset and counter saturation sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        InstrReqF;
    logic [31:0] PCF;
    logic        HazStallF;
    logic        FetchKill;
    logic        DataReqM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic [31:0] ReadDataM;
    logic        DataDoneM;
    logic        StallAllMem;
    logic        FlushWMem;
    logic        StallFMem;
    logic        FlushDMem;
    logic [15:0] StallCycles;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .InstrReqF(InstrReqF), .PCF(PCF), .HazStallF(HazStallF), .FetchKill(FetchKill),
        .DataReqM(DataReqM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData),
        .InstrF(InstrF), .InstrValidF(InstrValidF), .ReadDataM(ReadDataM), .DataDoneM(DataDoneM),
        .StallAllMem(StallAllMem), .FlushWMem(FlushWMem), .StallFMem(StallFMem), .FlushDMem(FlushDMem),
        .StallCycles(StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] pcf;
        logic        haz;
        logic        kill;
        logic        dreq;
        logic        mwr;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_rdata;
        logic        e_done;
        logic        e_sall;
        logic        e_sf;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t v(
        input logic ireq, input logic [31:0] pcf, input logic haz, input logic kill,
        input logic dreq, input logic mwr, input logic [31:0] alu, input logic [31:0] wd,
        input logic ack, input logic [31:0] rd,
        input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic e_iv, input logic [31:0] e_instr, input logic [31:0] e_rdata,
        input logic e_done, input logic e_sall, input logic e_sf);
        vec_t r;
        r.ireq = ireq; r.pcf = pcf; r.haz = haz; r.kill = kill; r.dreq = dreq; r.mwr = mwr;
        r.alu = alu; r.wd = wd; r.ack = ack; r.rd = rd;
        r.e_req = e_req; r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata; r.e_iv = e_iv;
        r.e_instr = e_instr; r.e_rdata = e_rdata; r.e_done = e_done; r.e_sall = e_sall; r.e_sf = e_sf;
        return r;
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        InstrReqF = x.ireq; PCF = x.pcf; HazStallF = x.haz; FetchKill = x.kill;
        DataReqM = x.dreq; MemWriteM = x.mwr; ALUOutM = x.alu; WriteDataM = x.wd;
        MemAck = x.ack; MemRData = x.rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [135:0] act;
        logic [135:0] exp;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));

        // Fetch @0x100, load @0x200 with fetch pending, fetch @0x104 held 3 cycles by HazStallF,
        // store of 0xDEADBEEF @0x300, killed fetch @0x108, refetch @0x400, kill of a held
        // instruction, stray MemAck in IDLE.
        vecs[0]  = v(1,32'h100,0,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h0,  32'h0,        0,32'h0,       32'h0,       0,0,1);
        vecs[1]  = v(1,32'h100,0,0, 0,0,32'h0,32'h0, 0,32'h0,         1,0,32'h100,32'h0,        0,32'h0,       32'h0,       0,0,1);
        vecs[2]  = v(1,32'h100,0,0, 0,0,32'h0,32'h0, 1,32'hE3A01005,  1,0,32'h100,32'h0,        0,32'h0,       32'h0,       0,0,1);
        vecs[3]  = v(1,32'h100,0,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h100,32'h0,        1,32'hE3A01005,32'h0,       0,0,0);
        vecs[4]  = v(1,32'h104,0,0, 1,0,32'h200,32'h0, 0,32'h0,       0,0,32'h100,32'h0,        0,32'hE3A01005,32'h0,       0,1,0);
        vecs[5]  = v(1,32'h104,0,0, 1,0,32'h200,32'h0, 1,32'h12345678,1,0,32'h200,32'h0,        0,32'hE3A01005,32'h0,       0,1,0);
        vecs[6]  = v(1,32'h104,0,0, 1,0,32'h200,32'h0, 0,32'h0,       0,0,32'h200,32'h0,        0,32'hE3A01005,32'h12345678,1,0,1);
        vecs[7]  = v(1,32'h104,0,0, 0,0,32'h0,32'h0, 1,32'hE1A00000,  1,0,32'h104,32'h0,        0,32'hE3A01005,32'h12345678,0,0,1);
        vecs[8]  = v(1,32'h108,1,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h104,32'h0,        1,32'hE1A00000,32'h12345678,0,0,0);
        vecs[9]  = v(1,32'h108,1,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h104,32'h0,        1,32'hE1A00000,32'h12345678,0,0,0);
        vecs[10] = v(1,32'h108,1,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h104,32'h0,        1,32'hE1A00000,32'h12345678,0,0,0);
        vecs[11] = v(1,32'h108,0,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h104,32'h0,        1,32'hE1A00000,32'h12345678,0,0,0);
        vecs[12] = v(1,32'h108,0,0, 1,1,32'h300,32'hDEADBEEF, 0,32'h0,0,0,32'h104,32'h0,        0,32'hE1A00000,32'h12345678,0,1,0);
        vecs[13] = v(1,32'h108,0,0, 1,1,32'h300,32'hDEADBEEF, 0,32'h0,1,1,32'h300,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,0,1,0);
        vecs[14] = v(1,32'h108,0,0, 1,1,32'h300,32'hDEADBEEF, 1,32'hAAAA5555,1,1,32'h300,32'hDEADBEEF,0,32'hE1A00000,32'h12345678,0,1,0);
        vecs[15] = v(1,32'h108,0,0, 1,1,32'h300,32'hDEADBEEF, 0,32'h0,0,1,32'h300,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,1,0,1);
        vecs[16] = v(1,32'h108,0,1, 0,0,32'h0,32'h0, 0,32'h0,         1,0,32'h108,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,0,0,1);
        vecs[17] = v(1,32'h400,0,0, 0,0,32'h0,32'h0, 1,32'hBADBAD00,  1,0,32'h108,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,0,0,1);
        vecs[18] = v(1,32'h400,0,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h108,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,0,0,1);
        vecs[19] = v(1,32'h400,0,0, 0,0,32'h0,32'h0, 0,32'h0,         1,0,32'h400,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,0,0,1);
        vecs[20] = v(1,32'h400,0,0, 0,0,32'h0,32'h0, 1,32'hE3A02007,  1,0,32'h400,32'hDEADBEEF, 0,32'hE1A00000,32'h12345678,0,0,1);
        vecs[21] = v(1,32'h404,1,1, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h400,32'hDEADBEEF, 1,32'hE3A02007,32'h12345678,0,0,0);
        vecs[22] = v(0,32'h404,0,0, 0,0,32'h0,32'h0, 1,32'hFFFFFFFF,  0,0,32'h400,32'hDEADBEEF, 0,32'hE3A02007,32'h12345678,0,0,0);
        vecs[23] = v(0,32'h0,  0,0, 0,0,32'h0,32'h0, 0,32'h0,         0,0,32'h400,32'hDEADBEEF, 0,32'hE3A02007,32'h12345678,0,0,0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        act = {MemReq, MemWE, MemAddr, MemWData, InstrValidF, InstrF, ReadDataM, DataDoneM, StallCycles};
        check("reset_state", act, 136'd0);

        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            drive(vecs[k]);
            @(negedge clk);
            act = {MemReq, MemWE, MemAddr, MemWData, InstrValidF, InstrF, ReadDataM, DataDoneM,
                   StallAllMem, FlushWMem, StallFMem, FlushDMem};
            exp = {vecs[k].e_req, vecs[k].e_we, vecs[k].e_addr, vecs[k].e_wdata, vecs[k].e_iv,
                   vecs[k].e_instr, vecs[k].e_rdata, vecs[k].e_done,
                   vecs[k].e_sall, vecs[k].e_sall, vecs[k].e_sf, vecs[k].e_sf};
            check($sformatf("vec[%0d]", k), act, exp);
        end

        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_count", {120'd0, StallCycles}, 136'd16);

        // Reset in the middle of a store request.
        @(posedge clk);
        #1;
        drive(v(0,0,0,0, 1,1,32'h500,32'h55, 0,0, 0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pre_req", {103'd0, MemReq, MemAddr}, {103'd0, 1'b1, 32'h500});
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        act = {MemReq, MemWE, MemAddr, MemWData, InstrValidF, InstrF, ReadDataM, DataDoneM, StallCycles};
        check("rst_mid_data", act, 136'd0);

        // Long unanswered load stall drives the counter into saturation.
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(v(0,0,0,0, 1,0,32'h600,32'h0, 0,0, 0,0,0,0,0,0,0,0,0,0));
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_count", {120'd0, StallCycles}, {120'd0, 16'hFFFF});
        check("sat_req_held", {103'd0, MemReq, MemAddr}, {103'd0, 1'b1, 32'h600});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat_hold", {120'd0, StallCycles}, {120'd0, 16'hFFFF});

        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage ARM pipeline.
- A 3-state FSM grants the port, holds each request stable until the memory acknowledges it, and registers the returned data.
- Generates memory-stall and bubble controls that the top level ORs with the hazard unit's stall/flush outputs.
- Also keeps a saturating count of memory-stall cycles for performance measurement.

Parameters:
- WIDTH, 32, data and address width.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- InstrReqF  in  1  IF stage requests the instruction at PCF
- PCF  in  WIDTH  fetch address
- HazStallF  in  1  hazard unit is stalling IF/ID (fetched instruction not consumed)
- FetchKill  in  1  redirect/flush: discard any in-flight or held fetch
- DataReqM  in  1  MEM stage holds a load or store
- MemWriteM  in  1  1 = store, 0 = load
- ALUOutM  in  WIDTH  data address
- WriteDataM  in  WIDTH  store data
- MemReq  out  1  request to memory, registered
- MemWE  out  1  write enable, registered
- MemAddr  out  WIDTH  registered address
- MemWData  out  WIDTH  registered write data
- MemAck  in  1  one-cycle acknowledge; earliest one cycle after MemReq rises
- MemRData  in  WIDTH  read data, valid with MemAck
- InstrF  out  WIDTH  fetched instruction, registered
- InstrValidF  out  1  InstrF holds an unconsumed instruction
- ReadDataM  out  WIDTH  load data, registered
- DataDoneM  out  1  one-cycle pulse: MEM access complete
- StallAllMem  out  1  stall F, D, E, M
- FlushWMem  out  1  bubble into WB
- StallFMem  out  1  stall F only
- FlushDMem  out  1  bubble into ID
- StallCycles  out  CNT_WIDTH  saturating count of cycles with StallAllMem or StallFMem

Behaviour:
- States: IDLE, DATA, FETCH.
- Reset values: state IDLE; all registered outputs 0. Reset mid-transaction abandons it immediately; memory shares the same reset.

IDLE:
- If DataReqM and not DataDoneM: latch ALUOutM, WriteDataM and MemWriteM into MemAddr, MemWData and MemWE; go to DATA.
- Else if InstrReqF, not InstrValidF and not FetchKill: latch PCF, clear MemWE; go to FETCH.
- Data always has priority over fetch, because MEM holds the older instruction.

DATA:
- MemReq=1 with address, data and WE held stable.
- On MemAck: go to IDLE, drop MemReq. In the next cycle DataDoneM=1, and ReadDataM=MemRData if it was a load (unchanged for a store).
- DataDoneM is high for exactly one cycle.

FETCH:
- MemReq=1.
- On MemAck: go to IDLE and set InstrF=MemRData with InstrValidF=1, unless the squash flag is set.
- FetchKill while in FETCH sets the squash flag. The response is then discarded and the flag is cleared on MemAck.

InstrValidF clear rule:
- Cleared when the instruction is consumed: InstrValidF and not StallAllMem and not HazStallF.
- Also cleared by FetchKill; FetchKill has priority over consumption.

Stall equations (combinational):
- StallAllMem = DataReqM and not DataDoneM.
- FlushWMem = StallAllMem.
- StallFMem = InstrReqF and not InstrValidF and not StallAllMem.
- FlushDMem = StallFMem.

Timing:
- With MemAck in the first possible cycle, a load stalls for 2 cycles (decision cycle plus request cycle). Done comes in the 3rd cycle, when the pipeline advances.
- Back-to-back accesses: a new grant can be issued in the cycle after MemAck.

Other rules:
- A MemAck while in IDLE is ignored.
- StallCycles increments by 1 per stalled cycle and saturates at all-ones.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, DATA=2'd1, FETCH=2'd2).
- Single module. The stall counter is small enough to stay inline.

Test Plan:
- Fetch only: InstrReqF=1, PCF=0x100, MemAck on the 2nd request cycle with MemRData=0xE3A01005 -> StallFMem high for 3 cycles, then InstrF=0xE3A01005 and InstrValidF=1.
- Load while fetch pending: DataReqM and InstrReqF both high in IDLE, ALUOutM=0x200 -> DATA granted first with MemAddr=0x200 and MemWE=0; ReadDataM equals MemRData one cycle after ack; the fetch is granted next cycle.
- Store: MemWriteM=1, WriteDataM=0xDEADBEEF -> MemWE=1 and MemWData=0xDEADBEEF held until ack; DataDoneM pulses exactly once.
- FetchKill during FETCH -> MemAck response discarded, InstrValidF stays 0, next fetch issued at the new PCF.
- Held instruction with HazStallF=1 for 3 cycles -> InstrValidF stays 1 and no new MemReq; cleared the cycle HazStallF drops.
- Reset asserted during DATA, plus a counter check -> MemReq=0 next cycle, all outputs 0; StallCycles saturates at 0xFFFF (run with CNT_WIDTH=16 and a forced long stall).
